// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Brief    : Execute-side, data-memory and write-back signal bundle for the
//            SPARC memory stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Execute side
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alures;
    logic [DATA_W-1:0] ex_valD;
    logic [REG_W-1:0]  ex_rd;
    logic [1:0]        ex_op;
    logic [2:0]        ex_op2;
    logic [5:0]        ex_op3;
    logic              mem_ready;
    // Data memory port
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    // Write-back side
    logic              wb_valid;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  ex_ready, ex_alures, ex_valD, ex_rd, ex_op, ex_op2, ex_op3,
        input  dmem_ack, dmem_rdata,
        output mem_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output wb_valid, wb_we, wb_rd, wb_data
    );

    modport slave (
        output ex_ready, ex_alures, ex_valD, ex_rd, ex_op, ex_op2, ex_op3,
        output dmem_ack, dmem_rdata,
        input  mem_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  wb_valid, wb_we, wb_rd, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : SPARC memory stage: big-endian byte/half/word loads and stores
//            over a req/ack port, registered write-back. Optional macro
//            MEM_ALIGN_TRAP_EN adds mem_trap for misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_access_stage_if.master  bus
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic                mem_trap
`endif
);
    localparam logic [1:0] c_SZ_WORD = 2'b00;
    localparam logic [1:0] c_SZ_BYTE = 2'b01;
    localparam logic [1:0] c_SZ_HALF = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              store_q, store_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              w_is_mem;
    logic              w_trap;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [DATA_W-1:0] w_ld_data;

    // LD/LDUB/LDUH/LDSB/LDSH/ST/STB/STH; op3[1:0] = size, op3[2] = store, op3[3] = signed
    assign w_is_mem = (bus.ex_op == 2'b11) &&
                      (bus.ex_op3 inside {6'b000000, 6'b000001, 6'b000010, 6'b001001,
                                          6'b001010, 6'b000100, 6'b000101, 6'b000110});

`ifdef MEM_ALIGN_TRAP_EN
    logic w_misaligned;
    logic mem_trap_q;

    assign w_misaligned = ((bus.ex_op3[1:0] == c_SZ_HALF) && bus.ex_alures[0]) ||
                          ((bus.ex_op3[1:0] == c_SZ_WORD) && (bus.ex_alures[1:0] != 2'b00));
    assign w_trap       = w_is_mem && w_misaligned;
    assign mem_trap     = mem_trap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_trap_q <= 1'b0;
        end else begin
            mem_trap_q <= (state_q == S_IDLE) && bus.ex_ready && w_trap;
        end
    end
`else
    assign w_trap = 1'b0;
`endif

    // Store lane selection; misaligned halves fall back to off[1]
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.ex_valD;
        case (bus.ex_op3[1:0])
            c_SZ_BYTE: begin
                w_be    = 4'b1000 >> bus.ex_alures[1:0];
                w_wdata = {4{bus.ex_valD[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = bus.ex_alures[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{bus.ex_valD[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.ex_valD;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = bus.dmem_rdata[31:24];
        case (off_q)
            2'd0:    w_ld_byte = bus.dmem_rdata[31:24];
            2'd1:    w_ld_byte = bus.dmem_rdata[23:16];
            2'd2:    w_ld_byte = bus.dmem_rdata[15:8];
            default: w_ld_byte = bus.dmem_rdata[7:0];
        endcase
        w_ld_half = off_q[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
        case (size_q)
            c_SZ_BYTE: w_ld_data = {{(DATA_W-8){signed_q & w_ld_byte[7]}}, w_ld_byte};
            c_SZ_HALF: w_ld_data = {{(DATA_W-16){signed_q & w_ld_half[15]}}, w_ld_half};
            default:   w_ld_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        rd_d         = rd_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        store_d      = store_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_ready) begin
                    if (w_trap) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        wb_data_d  = bus.ex_alures;
                    end else if (w_is_mem) begin
                        state_d      = S_WAIT;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = bus.ex_op3[2];
                        dmem_addr_d  = {bus.ex_alures[DATA_W-1:2], 2'b00};
                        dmem_wdata_d = w_wdata;
                        dmem_be_d    = w_be;
                        rd_d         = bus.ex_rd;
                        off_d        = bus.ex_alures[1:0];
                        size_d       = bus.ex_op3[1:0];
                        signed_d     = bus.ex_op3[3];
                        store_d      = bus.ex_op3[2];
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (bus.ex_op == 2'b10) && (bus.ex_rd != '0);
                        wb_rd_d    = bus.ex_rd;
                        wb_data_d  = bus.ex_alures;
                    end
                end
            end
            S_WAIT: begin
                if (bus.dmem_ack) begin
                    state_d    = S_IDLE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = !store_q && (rd_q != '0);
                    wb_data_d  = store_q ? '0 : w_ld_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            rd_q         <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            store_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            rd_q         <= rd_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            store_q      <= store_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign bus.mem_ready  = (state_q == S_IDLE);
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_we      = wb_we_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Self-checking bench for mem_access_stage with a write-back
//            scoreboard and a scripted data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    localparam logic [5:0] c_LD   = 6'b000000;
    localparam logic [5:0] c_LDUB = 6'b000001;
    localparam logic [5:0] c_LDUH = 6'b000010;
    localparam logic [5:0] c_LDSB = 6'b001001;
    localparam logic [5:0] c_LDSH = 6'b001010;
    localparam logic [5:0] c_ST   = 6'b000100;
    localparam logic [5:0] c_STB  = 6'b000101;
    localparam logic [5:0] c_STH  = 6'b000110;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_data;
    } wb_exp_t;

    logic    clk = 1'b0;
    logic    reset;
    int      n_tests = 0;
    int      n_fail  = 0;
    wb_exp_t r_sb[$];

    always #5 clk = ~clk;

    mem_access_stage_if bus ();
`ifdef MEM_ALIGN_TRAP_EN
    logic mem_trap;
`endif

    mem_access_stage dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef MEM_ALIGN_TRAP_EN
        ,
        .mem_trap (mem_trap)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [5:0] op3, input logic [1:0] off);
        if (op3[1:0] == 2'b01) begin
            case (off)
                2'd0:    return 4'b1000;
                2'd1:    return 4'b0100;
                2'd2:    return 4'b0010;
                default: return 4'b0001;
            endcase
        end else if (op3[1:0] == 2'b10) begin
            return off[1] ? 4'b0011 : 4'b1100;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op3, input logic [31:0] v);
        if (op3 == c_STB) return {v[7:0], v[7:0], v[7:0], v[7:0]};
        if (op3 == c_STH) return {v[15:0], v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op3, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[31 - 8*off -: 8];
        h = (off >= 2) ? d[15:0] : d[31:16];
        case (op3)
            c_LDUB:  return {24'h0, b};
            c_LDSB:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            c_LDUH:  return {16'h0, h};
            c_LDSH:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Write-back monitor: every wb_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        wb_exp_t e;
        if (bus.wb_valid === 1'b1) begin
            if (r_sb.size() == 0) begin
                check_eq("wb_unexpected", {31'h0, bus.wb_valid}, 32'h0);
            end else begin
                e = r_sb.pop_front();
                check_eq("wb_we", {31'h0, bus.wb_we}, {31'h0, e.we});
                check_eq("wb_rd", {27'h0, bus.wb_rd}, {27'h0, e.rd});
                if (e.chk_data) check_eq("wb_data", bus.wb_data, e.data);
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [5:0] op3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] vald);
        bus.ex_ready  = 1'b1;
        bus.ex_op     = op;
        bus.ex_op2    = 3'b100;
        bus.ex_op3    = op3;
        bus.ex_rd     = rd;
        bus.ex_alures = alu;
        bus.ex_valD   = vald;
    endtask

    task automatic do_alu(input string tag, input logic [1:0] op, input logic [5:0] op3,
                          input logic [4:0] rd, input logic [31:0] alu);
        drive(op, op3, rd, alu, 32'h0);
        r_sb.push_back('{we: (op == 2'b10) && (rd != 5'd0), rd: rd, data: alu, chk_data: 1'b1});
        @(negedge clk);
        bus.ex_ready = 1'b0;
        check_eq({tag, "_wbv"}, {31'h0, bus.wb_valid}, 32'h1);
        check_eq({tag, "_rdy_req"}, {30'h0, bus.mem_ready, bus.dmem_req}, 32'h2);
    endtask

    task automatic do_mem(input string tag, input logic [5:0] op3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] vald, input int lat,
                          input logic [31:0] rdata, input bit hold_ex);
        bit is_st;
        is_st = (op3 == c_ST) || (op3 == c_STB) || (op3 == c_STH);
        drive(2'b11, op3, rd, alu, vald);
        r_sb.push_back('{we: !is_st && (rd != 5'd0), rd: rd,
                         data: m_load(op3, alu[1:0], rdata), chk_data: !is_st});
        @(negedge clk);
        if (hold_ex) drive(2'b10, 6'b000000, 5'd9, 32'h0BAD, 32'h0);
        else bus.ex_ready = 1'b0;
        check_eq({tag, "_req_rdy"}, {30'h0, bus.dmem_req, bus.mem_ready}, 32'h2);
        check_eq({tag, "_we"}, {31'h0, bus.dmem_we}, {31'h0, is_st});
        check_eq({tag, "_addr"}, bus.dmem_addr, alu & 32'hFFFF_FFFC);
        check_eq({tag, "_be"}, {28'h0, bus.dmem_be}, {28'h0, m_be(op3, alu[1:0])});
        if (is_st) check_eq({tag, "_wdata"}, bus.dmem_wdata, m_wdata(op3, vald));
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check_eq({tag, "_stall"}, {30'h0, bus.dmem_req, bus.mem_ready}, 32'h2);
            check_eq({tag, "_addr_hold"}, bus.dmem_addr, alu & 32'hFFFF_FFFC);
        end
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        @(negedge clk);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        bus.ex_ready   = 1'b0;
        check_eq({tag, "_done"}, {29'h0, bus.wb_valid, bus.mem_ready, bus.dmem_req}, 32'h6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.ex_ready = 1'b0; bus.ex_alures = '0; bus.ex_valD = '0; bus.ex_rd = '0;
        bus.ex_op = '0; bus.ex_op2 = '0; bus.ex_op3 = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'h0, bus.mem_ready}, 32'h1);
        check_eq("rst_req_we", {30'h0, bus.dmem_req, bus.dmem_we}, 32'h0);
        check_eq("rst_addr", bus.dmem_addr, 32'h0);
        check_eq("rst_wdata", bus.dmem_wdata, 32'h0);
        check_eq("rst_be", {28'h0, bus.dmem_be}, 32'h0);
        check_eq("rst_wb", {bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data[24:0]}, 32'h0);
`ifdef MEM_ALIGN_TRAP_EN
        check_eq("rst_trap", {31'h0, mem_trap}, 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        do_alu("add",     2'b10, 6'b000000, 5'd3,  32'h0000_1234);
        do_alu("add_r0",  2'b10, 6'b000000, 5'd0,  32'h5555_0000);
        do_alu("sethi",   2'b00, 6'b000000, 5'd0,  32'h0040_0000);
        do_alu("call",    2'b01, 6'b000000, 5'd15, 32'h0000_8000);
        do_alu("op3_nop", 2'b11, 6'b000011, 5'd4,  32'h0000_0100);
        @(negedge clk);
        check_eq("idle_wbv", {31'h0, bus.wb_valid}, 32'h0);

        do_mem("ldsb", c_LDSB, 5'd1, 32'h0000_0101, 32'h0, 3, 32'h11F2_3344, 1'b0);
        do_mem("ldub", c_LDUB, 5'd2, 32'h0000_0103, 32'h0, 1, 32'h1122_33F4, 1'b0);
        do_mem("ldsh", c_LDSH, 5'd5, 32'h0000_0100, 32'h0, 2, 32'h8001_7777, 1'b0);
        do_mem("lduh", c_LDUH, 5'd6, 32'h0000_0102, 32'h0, 2, 32'h1234_ABCD, 1'b0);
        do_mem("ld",   c_LD,   5'd7, 32'h0000_0200, 32'h0, 4, 32'hCAFE_F00D, 1'b1);
        do_mem("ld_r0", c_LD,  5'd0, 32'h0000_0204, 32'h0, 1, 32'h1357_9BDF, 1'b0);
        do_mem("sth",  c_STH,  5'd8, 32'h0000_0202, 32'h0000_ABCD, 2, 32'h0, 1'b0);
        do_mem("stb",  c_STB,  5'd8, 32'h0000_0301, 32'h1234_565A, 1, 32'h0, 1'b0);
        do_mem("st",   c_ST,   5'd8, 32'h0000_0400, 32'hDEAD_BEEF, 3, 32'h0, 1'b1);

`ifdef MEM_ALIGN_TRAP_EN
        drive(2'b11, c_LD, 5'd10, 32'h0000_0102, 32'h0);
        r_sb.push_back('{we: 1'b0, rd: 5'd10, data: 32'h0, chk_data: 1'b0});
        @(negedge clk);
        bus.ex_ready = 1'b0;
        check_eq("trap_pulse", {29'h0, mem_trap, bus.wb_valid, bus.dmem_req}, 32'h6);
        check_eq("trap_rdy", {31'h0, bus.mem_ready}, 32'h1);
        @(negedge clk);
        check_eq("trap_clear", {30'h0, mem_trap, bus.dmem_req}, 32'h0);
`else
        do_mem("mis_lduh", c_LDUH, 5'd11, 32'h0000_0103, 32'h0, 2, 32'h1234_ABCD, 1'b0);
        do_mem("mis_ld",   c_LD,   5'd12, 32'h0000_0102, 32'h0, 1, 32'h89AB_CDEF, 1'b0);
`endif

        // Reset during an outstanding access, then a stale ack
        drive(2'b11, c_LD, 5'd4, 32'h0000_0500, 32'h0);
        @(negedge clk);
        bus.ex_ready = 1'b0;
        check_eq("rstw_req", {31'h0, bus.dmem_req}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rstw_drop", {30'h0, bus.dmem_req, bus.mem_ready}, 32'h1);
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        check_eq("late_ack_wbv", {31'h0, bus.wb_valid}, 32'h0);
        @(negedge clk);
        check_eq("late_ack_idle", {29'h0, bus.wb_valid, bus.mem_ready, bus.dmem_req}, 32'h2);

        for (int i = 0; i < 8; i++) begin
            do_alu("rnd", 2'($urandom_range(0, 2)), 6'($urandom), 5'($urandom), $urandom);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_drain", r_sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
